// File: rtl/demux_sched_pkg.sv
// ---------------------------------------------------------------------------
// demux_sched_pkg
//
// Purpose : Shared definitions for the round-robin demux scheduler.
//           Holds the channel count, channel index width, the scheduler
//           state enumeration and a one-hot helper used to build the
//           per-channel grant vector from a channel index.
//
// Contents:
//   NUM_CH        - number of requesters sharing the demux (4)
//   CH_W          - width of a channel index (2)
//   sched_state_t - IDLE / GRANT / GAP scheduler states
//   onehot4(ch)   - 4-bit one-hot vector with bit 'ch' set
// ---------------------------------------------------------------------------
package demux_sched_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    // IDLE  : nobody owns the demux, waiting for a request
    // GRANT : one channel owns the demux, enable is high
    // GAP   : single dead cycle between grants so sig never moves while enabled
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    // Turns a channel index into the matching one-hot grant vector.
    function automatic logic [NUM_CH-1:0] onehot4(input logic [CH_W-1:0] ch);
        return 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/demux_rr_sched_pick.sv
// ---------------------------------------------------------------------------
// rr_pick4
//
// Purpose : Purely combinational round-robin picker for four requesters.
//           The search starts at the channel after the most recently served
//           one and wraps around, so the last served channel is considered
//           last; it can still win when it is the only requester.
//
// Ports:
//   req     [3:0] in  - per-channel request bits
//   last_ch [1:0] in  - channel that was served most recently
//   valid         out - at least one request is pending
//   ch      [1:0] out - winning channel (holds last_ch when nothing wins)
// ---------------------------------------------------------------------------
module rr_pick4
    import demux_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_ch,
    output logic              valid,
    output logic [CH_W-1:0]   ch
);

    // Walk the four offsets 1..4 from last_ch. The 2-bit add wraps on its
    // own, and offset 4 lands back on last_ch so it is checked last. The
    // first set bit found wins; later hits are ignored via the valid flag.
    always_comb begin
        logic [CH_W-1:0] idx;
        valid = 1'b0;
        ch    = last_ch;
        idx   = last_ch;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = last_ch + CH_W'(i);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                ch    = idx;
            end
        end
    end

endmodule

// File: rtl/demux_rr_sched.sv
// ---------------------------------------------------------------------------
// demux_rr_sched
//
// Purpose : Round-robin scheduler sharing a 1-to-4 demux between four
//           requesters. Exactly one requester owns the routing path at a
//           time; each grant lasts at most MAX_HOLD cycles, and a single
//           dead cycle is inserted between grants so the demux select never
//           changes while the demux is enabled.
//
// Parameters:
//   MAX_HOLD - maximum consecutive enabled cycles per grant (1..255)
//
// Ports:
//   clk            in  - clock, all state changes on the rising edge
//   rst_n          in  - synchronous active-low reset
//   req      [3:0] in  - per-channel requests, bit i asks for output i
//   sched_en       in  - allows new grants; a running grant always finishes
//   enable         out - demux enable
//   sig      [1:0] out - demux select, current or most recent grant
//   grant    [3:0] out - one-hot owner while enable is high, else zero
//   timeout        out - one-cycle pulse when a grant ends on hold expiry
// ---------------------------------------------------------------------------
module demux_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              sched_en,
    output logic              enable,
    output logic [CH_W-1:0]   sig,
    output logic [NUM_CH-1:0] grant,
    output logic              timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic [CH_W-1:0]   last_ch;
    logic [CH_W-1:0]   last_ch_nxt;
    logic [CH_W-1:0]   sig_nxt;
    logic [NUM_CH-1:0] grant_nxt;
    logic              enable_nxt;
    logic              timeout_nxt;

    logic              pick_valid;
    logic [CH_W-1:0]   pick_ch;

    // Current owner still asking, and current owner out of hold budget.
    logic              owner_req;
    logic              hold_done;

    // The picker only matters in IDLE and GAP. In GAP last_ch has already
    // been updated to the channel just served, so it naturally drops to the
    // back of the queue for the next arbitration.
    rr_pick4 u_pick (
        .req     (req),
        .last_ch (last_ch),
        .valid   (pick_valid),
        .ch      (pick_ch)
    );

    assign owner_req = req[sig];
    assign hold_done = (hold_cnt == HOLD_MAX);

    // State register and every registered output. Reset puts last_ch at 3
    // so channel 0 is first in line once reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last_ch  <= CH_W'(NUM_CH - 1);
            sig      <= '0;
            grant    <= '0;
            enable   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            last_ch  <= last_ch_nxt;
            sig      <= sig_nxt;
            grant    <= grant_nxt;
            enable   <= enable_nxt;
            timeout  <= timeout_nxt;
        end
    end

    // Next-state logic. In GRANT a dropped request is checked before hold
    // expiry so that a release on the last allowed cycle is not reported
    // as a timeout. sched_en only gates the start of a new grant.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sched_en && pick_valid) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req || hold_done) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (sched_en && pick_valid) begin
                    state_nxt = GRANT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: computes the values the output registers take at the
    // next edge. sig is held outside GRANT so it always shows the most
    // recent owner; timeout is only ever raised on the GRANT->GAP edge, so
    // it lives for exactly the one GAP cycle. hold_cnt starts at 1 with the
    // first enabled cycle and saturates at MAX_HOLD by construction.
    always_comb begin
        hold_cnt_nxt = '0;
        last_ch_nxt  = last_ch;
        sig_nxt      = sig;
        grant_nxt    = '0;
        enable_nxt   = 1'b0;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (state_nxt == GRANT) begin
                    sig_nxt      = pick_ch;
                    grant_nxt    = onehot4(pick_ch);
                    enable_nxt   = 1'b1;
                    hold_cnt_nxt = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (state_nxt == GAP) begin
                    last_ch_nxt = sig;
                    timeout_nxt = owner_req;
                end else begin
                    grant_nxt    = grant;
                    enable_nxt   = 1'b1;
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                hold_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_demux_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_demux_rr_sched
//
// Purpose : Directed self-checking bench for demux_rr_sched with the
//           default MAX_HOLD of 8. Inputs are driven and outputs are
//           sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_demux_rr_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       sched_en;
    logic       enable;
    logic [1:0] sig;
    logic [3:0] grant;
    logic       timeout;

    int tests_run;
    int tests_failed;

    demux_rr_sched #(.MAX_HOLD(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .sched_en (sched_en),
        .enable   (enable),
        .sig      (sig),
        .grant    (grant),
        .timeout  (timeout)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges, inputs idle, then release.
    task automatic do_reset();
        req      = 4'b0000;
        sched_en = 1'b1;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reset held 3 cycles with every channel requesting: outputs stay at
    // reset values, then channel 0 wins first.
    task automatic test_reset();
        req      = 4'hF;
        sched_en = 1'b1;
        rst_n    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if ({enable, sig, grant, timeout} !== 8'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_outputs cyc%0d: en=%b sig=%b grant=%b to=%b, required all zero",
                         c, enable, sig, grant, timeout);
            end
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({enable, sig, grant, timeout} !== {1'b1, 2'd0, 4'b0001, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_grant: en=%b sig=%b grant=%b to=%b, required en=1 sig=00 grant=0001 to=0",
                     enable, sig, grant, timeout);
        end
    endtask

    // Lone requester on ch2: 8 enabled cycles, timeout gap, re-grant.
    task automatic test_hold_expiry();
        do_reset();
        req = 4'b0100;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                tests_run++;
                if ({enable, sig, grant, timeout} !== {1'b1, 2'd2, 4'b0100, 1'b0}) begin
                    tests_failed++;
                    $display("[TB] FAIL hold_grant p%0d c%0d: en=%b sig=%b grant=%b to=%b, required en=1 sig=10 grant=0100 to=0",
                             p, c, enable, sig, grant, timeout);
                end
            end
            tick();
            tests_run++;
            if ({enable, sig, grant, timeout} !== {1'b0, 2'd2, 4'b0000, 1'b1}) begin
                tests_failed++;
                $display("[TB] FAIL hold_gap p%0d: en=%b sig=%b grant=%b to=%b, required en=0 sig=10 grant=0000 to=1",
                         p, enable, sig, grant, timeout);
            end
        end
        tick();
        tests_run++;
        if ({enable, grant} !== {1'b1, 4'b0100}) begin
            tests_failed++;
            $display("[TB] FAIL hold_regrant: en=%b grant=%b, required en=1 grant=0100", enable, grant);
        end
    endtask

    // All four requesting: 0001, 0010, 0100, 1000, 0001 with timeout gaps.
    task automatic test_round_robin();
        logic [3:0] exp_grant [5];
        exp_grant[0] = 4'b0001;
        exp_grant[1] = 4'b0010;
        exp_grant[2] = 4'b0100;
        exp_grant[3] = 4'b1000;
        exp_grant[4] = 4'b0001;
        do_reset();
        req = 4'hF;
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                tests_run++;
                if ({enable, sig, grant, timeout} !== {1'b1, 2'(p % 4), exp_grant[p], 1'b0}) begin
                    tests_failed++;
                    $display("[TB] FAIL rr_grant p%0d c%0d: en=%b sig=%b grant=%b to=%b, required en=1 sig=%0d grant=%b to=0",
                             p, c, enable, sig, grant, timeout, p % 4, exp_grant[p]);
                end
            end
            tick();
            tests_run++;
            if ({enable, grant, timeout} !== {1'b0, 4'b0000, 1'b1}) begin
                tests_failed++;
                $display("[TB] FAIL rr_gap p%0d: en=%b grant=%b to=%b, required en=0 grant=0000 to=1",
                         p, enable, grant, timeout);
            end
        end
    endtask

    // ch1 drops its request during its 4th enabled cycle: gap without
    // timeout, then idle.
    task automatic test_req_drop();
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests_run++;
            if ({enable, sig, grant} !== {1'b1, 2'd1, 4'b0010}) begin
                tests_failed++;
                $display("[TB] FAIL drop_grant c%0d: en=%b sig=%b grant=%b, required en=1 sig=01 grant=0010",
                         c, enable, sig, grant);
            end
        end
        req = 4'b0000;
        tick();
        tests_run++;
        if ({enable, grant, timeout} !== {1'b0, 4'b0000, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL drop_gap: en=%b grant=%b to=%b, required en=0 grant=0000 to=0",
                     enable, grant, timeout);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            tests_run++;
            if ({enable, grant, timeout} !== 6'b0) begin
                tests_failed++;
                $display("[TB] FAIL drop_idle c%0d: en=%b grant=%b to=%b, required all zero",
                         c, enable, grant, timeout);
            end
        end
    endtask

    // ch3 grant running when sched_en falls: it finishes, then idle until
    // sched_en returns, then ch0 wins.
    task automatic test_sched_en_low();
        do_reset();
        req = 4'b1000;
        tick();
        req      = 4'b1001;
        sched_en = 1'b0;
        tests_run++;
        if ({enable, sig, grant} !== {1'b1, 2'd3, 4'b1000}) begin
            tests_failed++;
            $display("[TB] FAIL sen_start: en=%b sig=%b grant=%b, required en=1 sig=11 grant=1000",
                     enable, sig, grant);
        end
        for (int c = 1; c < 8; c++) begin
            tick();
            tests_run++;
            if ({enable, sig, grant} !== {1'b1, 2'd3, 4'b1000}) begin
                tests_failed++;
                $display("[TB] FAIL sen_hold c%0d: en=%b sig=%b grant=%b, required en=1 sig=11 grant=1000",
                         c, enable, sig, grant);
            end
        end
        tick();
        tests_run++;
        if ({enable, grant, timeout} !== {1'b0, 4'b0000, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL sen_gap: en=%b grant=%b to=%b, required en=0 grant=0000 to=1",
                     enable, grant, timeout);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if ({enable, grant, timeout} !== 6'b0) begin
                tests_failed++;
                $display("[TB] FAIL sen_idle c%0d: en=%b grant=%b to=%b, required all zero",
                         c, enable, grant, timeout);
            end
        end
        sched_en = 1'b1;
        tick();
        tests_run++;
        if ({enable, sig, grant} !== {1'b1, 2'd0, 4'b0001}) begin
            tests_failed++;
            $display("[TB] FAIL sen_resume: en=%b sig=%b grant=%b, required en=1 sig=00 grant=0001",
                     enable, sig, grant);
        end
    endtask

    // Reset pulsed while ch1 holds the demux with hold count 4: outputs
    // clear at once, next grant is ch0 with a full 8-cycle budget.
    task automatic test_mid_grant_reset();
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            tick();
        end
        tests_run++;
        if ({enable, grant} !== {1'b1, 4'b0010}) begin
            tests_failed++;
            $display("[TB] FAIL mrst_pre: en=%b grant=%b, required en=1 grant=0010", enable, grant);
        end
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({enable, sig, grant, timeout} !== 8'b0) begin
            tests_failed++;
            $display("[TB] FAIL mrst_clear: en=%b sig=%b grant=%b to=%b, required all zero",
                     enable, sig, grant, timeout);
        end
        rst_n = 1'b1;
        req   = 4'hF;
        for (int c = 0; c < 8; c++) begin
            tick();
            tests_run++;
            if ({enable, sig, grant, timeout} !== {1'b1, 2'd0, 4'b0001, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL mrst_grant c%0d: en=%b sig=%b grant=%b to=%b, required en=1 sig=00 grant=0001 to=0",
                         c, enable, sig, grant, timeout);
            end
        end
        tick();
        tests_run++;
        if ({enable, timeout} !== {1'b0, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL mrst_gap: en=%b to=%b, required en=0 to=1", enable, timeout);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req          = 4'b0000;
        sched_en     = 1'b0;
        #1;
        test_reset();
        test_hold_expiry();
        test_round_robin();
        test_req_drop();
        test_sched_en_low();
        test_mid_grant_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
